// File: rtl/mfp_sdram_init_refresh_scheduler_if.sv
// Command-bus interface between the SDRAM init/refresh scheduler and its access engine.
// The master side drives the SDRAM pins and the grant; the slave side is the access engine.
interface mfp_sdram_init_refresh_scheduler_if;
    logic        acc_req;
    logic        acc_done;
    logic        acc_gnt;
    logic        sdram_cke;
    logic [3:0]  sdram_cmd;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_ba;
    logic        init_done;
    logic        ref_pending;
    logic        ref_overrun;

    modport master (
        input  acc_req, acc_done,
        output acc_gnt, sdram_cke, sdram_cmd, sdram_addr, sdram_ba,
               init_done, ref_pending, ref_overrun
    );

    modport slave (
        output acc_req, acc_done,
        input  acc_gnt, sdram_cke, sdram_cmd, sdram_addr, sdram_ba,
               init_done, ref_pending, ref_overrun
    );
endinterface

// File: rtl/mfp_sdram_init_refresh_scheduler.sv
// SDRAM power-up sequencer, periodic auto-refresh scheduler and bus arbiter
// between refresh and the AHB-side access engine.
module mfp_sdram_init_refresh_scheduler #(
    parameter int          DELAY_nCKE        = 20000,
    parameter int          DELAY_tRP         = 0,
    parameter int          DELAY_tRFC        = 4,
    parameter int          DELAY_tMRD        = 0,
    parameter int          DELAY_tREFI       = 390,
    parameter int          COUNT_initAutoRef = 8,
    parameter logic [12:0] MODE_REG          = 13'h020
) (
    input  logic                                  HCLK,
    input  logic                                  HRESETn,
    mfp_sdram_init_refresh_scheduler_if.master    sch
);

    localparam logic [3:0] CMD_INHIBIT = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_PRE     = 4'b0010;
    localparam logic [3:0] CMD_REF     = 4'b0001;
    localparam logic [3:0] CMD_LMR     = 4'b0000;

    localparam logic [3:0] S_INIT_WAIT = 4'd0;
    localparam logic [3:0] S_INIT_PRE  = 4'd1;
    localparam logic [3:0] S_INIT_TRP  = 4'd2;
    localparam logic [3:0] S_INIT_REF  = 4'd3;
    localparam logic [3:0] S_INIT_TRFC = 4'd4;
    localparam logic [3:0] S_INIT_LMR  = 4'd5;
    localparam logic [3:0] S_INIT_TMRD = 4'd6;
    localparam logic [3:0] S_IDLE      = 4'd7;
    localparam logic [3:0] S_GRANT     = 4'd8;
    localparam logic [3:0] S_REF_PRE   = 4'd9;
    localparam logic [3:0] S_REF_TRP   = 4'd10;
    localparam logic [3:0] S_REF_CMD   = 4'd11;
    localparam logic [3:0] S_REF_TRFC  = 4'd12;

    localparam int MAX_A = (DELAY_nCKE > DELAY_tRFC) ? DELAY_nCKE : DELAY_tRFC;
    localparam int MAX_B = (DELAY_tRP > DELAY_tMRD) ? DELAY_tRP : DELAY_tMRD;
    localparam int MAXD  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAXD + 2);
    localparam int TW    = $clog2(DELAY_tREFI + 1);
    localparam int RW    = $clog2(COUNT_initAutoRef + 1);

    localparam logic [CW-1:0] D_NCKE   = CW'(DELAY_nCKE);
    localparam logic [CW-1:0] D_TRP    = CW'(DELAY_tRP);
    localparam logic [CW-1:0] D_TRFC   = CW'(DELAY_tRFC);
    localparam logic [CW-1:0] D_TMRD   = CW'(DELAY_tMRD);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [TW-1:0] TREFI_M1 = TW'(DELAY_tREFI - 1);
    localparam logic [RW-1:0] N_IREF   = RW'(COUNT_initAutoRef);

    logic [3:0]    st, st_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [RW-1:0] irc, irc_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    debt, debt_n;
    logic          expire, ovr_n;
    logic [3:0]    cmd_n;
    logic [12:0]   addr_n;

    logic          cke_q, gnt_q, done_q, pend_q, ovr_q;
    logic [3:0]    cmd_q;
    logic [12:0]   addr_q;

    // Refresh timer and debt accounting; a REFRESH cancels a coincident expiry.
    always_comb begin
        expire  = done_q && (timer == '0);
        timer_n = timer;
        if (done_q) timer_n = expire ? TREFI_M1 : timer - 1'b1;
        debt_n = debt;
        if (expire && st != S_REF_CMD)
            debt_n = (debt == 3'd7) ? 3'd7 : debt + 3'd1;
        else if (!expire && st == S_REF_CMD)
            debt_n = debt - 3'd1;
        ovr_n = ovr_q | (expire && debt == 3'd7);
    end

    // Leaving a refresh arbitrates directly, so a waiting engine is granted
    // on the first cycle after the tRFC wait without an extra IDLE cycle.
    always_comb begin
        st_n  = st;
        cnt_n = cnt;
        irc_n = irc;
        case (st)
            S_INIT_WAIT: if (cnt == D_NCKE) begin st_n = S_INIT_PRE; cnt_n = '0; end
                         else cnt_n = cnt + 1'b1;
            S_INIT_PRE:  if (D_TRP == '0) st_n = S_INIT_REF;
                         else begin st_n = S_INIT_TRP; cnt_n = CNT_ONE; end
            S_INIT_TRP:  if (cnt >= D_TRP) st_n = S_INIT_REF;
                         else cnt_n = cnt + 1'b1;
            S_INIT_REF:  if (D_TRFC == '0) st_n = (irc == N_IREF) ? S_INIT_LMR : S_INIT_REF;
                         else begin st_n = S_INIT_TRFC; cnt_n = CNT_ONE; end
            S_INIT_TRFC: if (cnt >= D_TRFC) st_n = (irc == N_IREF) ? S_INIT_LMR : S_INIT_REF;
                         else cnt_n = cnt + 1'b1;
            S_INIT_LMR:  if (D_TMRD == '0) st_n = S_IDLE;
                         else begin st_n = S_INIT_TMRD; cnt_n = CNT_ONE; end
            S_INIT_TMRD: if (cnt >= D_TMRD) st_n = S_IDLE;
                         else cnt_n = cnt + 1'b1;
            S_IDLE:      if (debt != '0) st_n = S_REF_PRE;
                         else if (sch.acc_req) st_n = S_GRANT;
            S_GRANT:     if (sch.acc_done) st_n = S_IDLE;
            S_REF_PRE:   if (D_TRP == '0) st_n = S_REF_CMD;
                         else begin st_n = S_REF_TRP; cnt_n = CNT_ONE; end
            S_REF_TRP:   if (cnt >= D_TRP) st_n = S_REF_CMD;
                         else cnt_n = cnt + 1'b1;
            S_REF_CMD:   if (D_TRFC != '0) begin st_n = S_REF_TRFC; cnt_n = CNT_ONE; end
                         else if (debt_n != '0) st_n = S_REF_PRE;
                         else st_n = sch.acc_req ? S_GRANT : S_IDLE;
            S_REF_TRFC:  if (cnt < D_TRFC) cnt_n = cnt + 1'b1;
                         else if (debt != '0) st_n = S_REF_PRE;
                         else st_n = sch.acc_req ? S_GRANT : S_IDLE;
            default:     st_n = S_INIT_WAIT;
        endcase
        if (st_n == S_INIT_REF) irc_n = irc + 1'b1;
    end

    // Pin values are decoded from the next state so every output is a flop.
    always_comb begin
        cmd_n  = CMD_NOP;
        addr_n = '0;
        case (st_n)
            S_INIT_PRE, S_REF_PRE: begin cmd_n = CMD_PRE; addr_n = 13'h0400; end
            S_INIT_REF, S_REF_CMD: cmd_n = CMD_REF;
            S_INIT_LMR:            begin cmd_n = CMD_LMR; addr_n = MODE_REG; end
            default:               ;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            st     <= S_INIT_WAIT;
            cnt    <= '0;
            irc    <= '0;
            timer  <= TREFI_M1;
            debt   <= '0;
            cke_q  <= 1'b0;
            cmd_q  <= CMD_INHIBIT;
            addr_q <= '0;
            gnt_q  <= 1'b0;
            done_q <= 1'b0;
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            st     <= st_n;
            cnt    <= cnt_n;
            irc    <= irc_n;
            timer  <= timer_n;
            debt   <= debt_n;
            cke_q  <= (st_n != S_INIT_WAIT);
            cmd_q  <= cmd_n;
            addr_q <= addr_n;
            gnt_q  <= (st_n == S_GRANT);
            done_q <= done_q | (st_n == S_IDLE);
            pend_q <= (debt_n != '0);
            ovr_q  <= ovr_n;
        end
    end

    assign sch.sdram_cke   = cke_q;
    assign sch.sdram_cmd   = cmd_q;
    assign sch.sdram_addr  = addr_q;
    assign sch.sdram_ba    = 2'b00;
    assign sch.acc_gnt     = gnt_q;
    assign sch.init_done   = done_q;
    assign sch.ref_pending = pend_q;
    assign sch.ref_overrun = ovr_q;

endmodule

// File: tb/tb_mfp_sdram_init_refresh_scheduler.sv
// Bench for the SDRAM init/refresh scheduler: directed timeline checks plus
// randomized access traffic against a cycle-level command-queue reference model.
module tb_mfp_sdram_init_refresh_scheduler;
    localparam int NCKE = 4, TRP = 1, TRFC = 2, TMRD = 1, CNT = 2, TREFI = 50;
    localparam int INIT_LEN = NCKE + 2 + TRP + CNT * (1 + TRFC) + TMRD;
    localparam logic [3:0] C_INH = 4'hF, C_NOP = 4'h7, C_PRE = 4'h2, C_REF = 4'h1, C_LMR = 4'h0;
    localparam logic [12:0] MODE = 13'h020;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b1;
    always #5 HCLK = ~HCLK;

    mfp_sdram_init_refresh_scheduler_if sch();

    mfp_sdram_init_refresh_scheduler #(
        .DELAY_nCKE(NCKE), .DELAY_tRP(TRP), .DELAY_tRFC(TRFC), .DELAY_tMRD(TMRD),
        .DELAY_tREFI(TREFI), .COUNT_initAutoRef(CNT), .MODE_REG(MODE)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .sch(sch)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: cycle index since reset release, grant flag, debt, overrun,
    // and a queue of commands still to be issued by the current refresh.
    int cyc;
    bit m_gnt, m_ovr;
    int m_debt;
    logic [3:0] q[$];
    int hold;
    logic [3:0] e_cmd;
    logic [12:0] e_addr;
    logic e_cke, e_gnt, e_done, e_pend, e_ovr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [3:0] init_cmd(int k);
        int p;
        if (k < NCKE) return C_NOP;
        p = k - NCKE;
        if (p == 0) return C_PRE;
        p = p - 1 - TRP;
        if (p < 0) return C_NOP;
        if (p < CNT * (1 + TRFC)) return (p % (1 + TRFC) == 0) ? C_REF : C_NOP;
        p = p - CNT * (1 + TRFC);
        return (p == 0) ? C_LMR : C_NOP;
    endfunction

    function automatic logic [12:0] cmd_addr(logic [3:0] c);
        if (c == C_PRE) return 13'h0400;
        if (c == C_LMR) return MODE;
        return 13'h0000;
    endfunction

    task automatic set_exp(input logic [3:0] c);
        e_cmd  = c;
        e_addr = cmd_addr(c);
        e_cke  = (cyc >= NCKE);
        e_done = (cyc >= INIT_LEN);
        e_gnt  = m_gnt;
        e_pend = (m_debt != 0);
        e_ovr  = m_ovr;
    endtask

    // Advance the model from cycle cyc to cyc+1 using this cycle's inputs.
    task automatic model_advance();
        bit expire, did_ref;
        logic [3:0] nc;
        expire  = (cyc >= INIT_LEN) && ((cyc - INIT_LEN) % TREFI == TREFI - 1);
        did_ref = (cyc >= INIT_LEN) && (e_cmd == C_REF);
        nc = C_NOP;
        if (cyc + 1 <= INIT_LEN) nc = init_cmd(cyc + 1);
        else if (q.size() != 0) nc = q.pop_front();
        else if (m_gnt) begin
            if (sch.acc_done) m_gnt = 1'b0;
        end else if (m_debt != 0) begin
            q.push_back(C_PRE);
            repeat (TRP) q.push_back(C_NOP);
            q.push_back(C_REF);
            repeat (TRFC) q.push_back(C_NOP);
            nc = q.pop_front();
        end else if (sch.acc_req) m_gnt = 1'b1;
        if (expire) begin
            if (m_debt == 7) m_ovr = 1'b1;
            if (!did_ref && m_debt < 7) m_debt++;
        end else if (did_ref) m_debt--;
        cyc++;
        set_exp(nc);
    endtask

    task automatic cycle();
        @(negedge HCLK);
        chk("cmd",  32'(sch.sdram_cmd),   32'(e_cmd));
        chk("addr", 32'(sch.sdram_addr),  32'(e_addr));
        chk("ba",   32'(sch.sdram_ba),    32'(0));
        chk("cke",  32'(sch.sdram_cke),   32'(e_cke));
        chk("gnt",  32'(sch.acc_gnt),     32'(e_gnt));
        chk("done", 32'(sch.init_done),   32'(e_done));
        chk("pend", 32'(sch.ref_pending), 32'(e_pend));
        chk("ovr",  32'(sch.ref_overrun), 32'(e_ovr));
        model_advance();
        @(posedge HCLK);
        #1;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) cycle();
    endtask

    task automatic reset_release();
        @(negedge HCLK);
        HRESETn = 1'b1;
        cyc = 0; m_gnt = 1'b0; m_ovr = 1'b0; m_debt = 0;
        q.delete();
        set_exp(init_cmd(0));
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        sch.acc_req = 1'b0;
        sch.acc_done = 1'b0;
        cyc = -1;
        hold = 0;
        #3 HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_cmd",  32'(sch.sdram_cmd),   32'(C_INH));
        chk("rst_cke",  32'(sch.sdram_cke),   32'(0));
        chk("rst_addr", 32'(sch.sdram_addr),  32'(0));
        chk("rst_gnt",  32'(sch.acc_gnt),     32'(0));
        chk("rst_done", 32'(sch.init_done),   32'(0));
        chk("rst_pend", 32'(sch.ref_pending), 32'(0));
        chk("rst_ovr",  32'(sch.ref_overrun), 32'(0));
        reset_release();

        // Init timeline
        run_to(3);  chk("c3_cke", 32'(sch.sdram_cke), 32'(0));
        run_to(4);  chk("c4_pre", 32'(sch.sdram_cmd), 32'(C_PRE));
                    chk("c4_addr", 32'(sch.sdram_addr), 32'h400);
                    chk("c4_cke", 32'(sch.sdram_cke), 32'(1));
        run_to(6);  chk("c6_ref", 32'(sch.sdram_cmd), 32'(C_REF));
        run_to(9);  chk("c9_ref", 32'(sch.sdram_cmd), 32'(C_REF));
        run_to(12); chk("c12_lmr", 32'(sch.sdram_cmd), 32'(C_LMR));
                    chk("c12_addr", 32'(sch.sdram_addr), 32'h020);
        run_to(13); chk("c13_done", 32'(sch.init_done), 32'(0));
        run_to(14); chk("c14_done", 32'(sch.init_done), 32'(1));

        // Periodic refresh
        run_to(63); chk("c63_pend", 32'(sch.ref_pending), 32'(0));
        run_to(64); chk("c64_pend", 32'(sch.ref_pending), 32'(1));
        run_to(65); chk("c65_pre", 32'(sch.sdram_cmd), 32'(C_PRE));
        run_to(66); chk("c66_nop", 32'(sch.sdram_cmd), 32'(C_NOP));
        run_to(67); chk("c67_ref", 32'(sch.sdram_cmd), 32'(C_REF));
        run_to(115); chk("c115_pre", 32'(sch.sdram_cmd), 32'(C_PRE));

        // Request coinciding with debt becoming 1: refresh first
        run_to(164); sch.acc_req = 1'b1;
        run_to(167); chk("c167_ref", 32'(sch.sdram_cmd), 32'(C_REF));
        run_to(169); chk("c169_gnt", 32'(sch.acc_gnt), 32'(0));
        run_to(170); chk("c170_gnt", 32'(sch.acc_gnt), 32'(1));
        sch.acc_req = 1'b0;
        run_to(174); sch.acc_done = 1'b1; cycle(); sch.acc_done = 1'b0;
        chk("c175_gnt", 32'(sch.acc_gnt), 32'(0));
        run_to(177); sch.acc_done = 1'b1; cycle(); sch.acc_done = 1'b0;
        run_to(179); chk("stray_done_gnt", 32'(sch.acc_gnt), 32'(0));

        // Grant handshake from IDLE with no debt
        run_to(180); sch.acc_req = 1'b1; cycle(); sch.acc_req = 1'b0;
        chk("hs_gnt_t1", 32'(sch.acc_gnt), 32'(1));
        run_to(185); sch.acc_done = 1'b1;
        chk("hs_gnt_t5", 32'(sch.acc_gnt), 32'(1));
        cycle(); sch.acc_done = 1'b0;
        chk("hs_gnt_t6", 32'(sch.acc_gnt), 32'(0));

        // Long grant: debt saturates and overrun sets on the 8th expiry
        run_to(200); sch.acc_req = 1'b1; cycle(); sch.acc_req = 1'b0;
        run_to(563); chk("c563_ovr", 32'(sch.ref_overrun), 32'(0));
        run_to(564); chk("c564_ovr", 32'(sch.ref_overrun), 32'(1));
                     chk("c564_gnt", 32'(sch.acc_gnt), 32'(1));
        run_to(601); sch.acc_done = 1'b1; cycle(); sch.acc_done = 1'b0;
        chk("c602_gnt", 32'(sch.acc_gnt), 32'(0));
        run_to(603); chk("c603_pre", 32'(sch.sdram_cmd), 32'(C_PRE));
        run_to(655); chk("c655_pend", 32'(sch.ref_pending), 32'(0));
                     chk("c655_ovr", 32'(sch.ref_overrun), 32'(1));

        // Randomized access traffic, including stray acc_done pulses
        repeat (800) begin
            sch.acc_done = 1'b0;
            if (e_gnt) begin
                sch.acc_req = 1'b0;
                if (hold == 0) sch.acc_done = 1'b1;
                else hold--;
            end else if (!sch.acc_req && $urandom_range(0, 7) == 0) begin
                sch.acc_req = 1'b1;
                hold = int'($urandom_range(0, 12));
            end else if (!sch.acc_req && $urandom_range(0, 15) == 0) begin
                sch.acc_done = 1'b1;
            end
            cycle();
        end
        sch.acc_req = 1'b0;
        sch.acc_done = 1'b0;

        // Reset during the second init REFRESH, then the init timeline repeats
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        reset_release();
        run_to(9); chk("r9_ref", 32'(sch.sdram_cmd), 32'(C_REF));
        HRESETn = 1'b0;
        #1;
        chk("mid_rst_cke", 32'(sch.sdram_cke), 32'(0));
        chk("mid_rst_cmd", 32'(sch.sdram_cmd), 32'(C_INH));
        chk("mid_rst_addr", 32'(sch.sdram_addr), 32'(0));
        repeat (2) @(posedge HCLK);
        reset_release();
        run_to(3);  chk("r3_cke", 32'(sch.sdram_cke), 32'(0));
        run_to(4);  chk("r4_pre", 32'(sch.sdram_cmd), 32'(C_PRE));
        run_to(9);  chk("r9b_ref", 32'(sch.sdram_cmd), 32'(C_REF));
        run_to(12); chk("r12_lmr", 32'(sch.sdram_cmd), 32'(C_LMR));
        run_to(14); chk("r14_done", 32'(sch.init_done), 32'(1));
        run_to(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
